// File: rtl/counter_bus_slave_if.sv
// Register-side bus between a wait-state/read-valid master and the
// counter bus slave.
//
// Handshake: a request (read or write) is accepted in a cycle where it is
// asserted and waitrequest is 0. While waitrequest is 1 the master holds the
// request unchanged. A write completes in its accept cycle. An accepted read
// is answered by exactly one readdatavalid pulse carrying readdata.
interface counter_bus_slave_if;
  logic [1:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/counter_bus_slave.sv
// Bus responder for the counter peripheral core. Decodes the 2-bit word
// address, produces the core's write/read strobes and write data, returns
// read data after a fixed latency and latches the core interrupt pulse into
// a sticky write-1-to-clear pending flag with an overrun flag.
//
// Register map: 0 COUNTER (RW), 1 CONFIG (bit0 En, bit1 Dir, bit2 Ire),
// 2 STATUS (bit0 LT1000 RO, bit1 pending W1C, bit2 overrun W1C), 3 ID (RO).
module counter_bus_slave #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] DEVICE_ID    = 32'hC0DE_0001
) (
  input  logic                      clk,
  input  logic                      reset,
  counter_bus_slave_if.slave        bus,
  output logic [31:0]               counterIn,
  output logic                      counterEnIn,
  output logic                      counterDirIn,
  output logic                      counterIreIn,
  output logic                      counterWe,
  output logic                      counterRe,
  output logic                      counterConfigWe,
  output logic                      counterConfigRe,
  output logic                      counterStatusRe,
  input  logic [31:0]               counterOut,
  input  logic                      counterEnOut,
  input  logic                      counterDirOut,
  input  logic                      counterIreOut,
  input  logic                      counterLT1000Out,
  input  logic                      counterIrqOut,
  output logic                      irq,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  localparam logic [1:0] A_COUNTER = 2'd0;
  localparam logic [1:0] A_CONFIG  = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [2:0] LAT_LOAD  = 3'(READ_LATENCY - 1);

  state_t      state, state_next;
  logic [2:0]  lat_cnt, lat_cnt_next;
  logic [1:0]  rd_addr, rd_addr_next;
  logic [31:0] rd_mux;
  logic [31:0] be_mask;
  logic        pending, overrun;
  logic        clr_pending, clr_overrun;
  logic        wr_acc, rd_acc;

  // A write wins over a simultaneous read; nothing is accepted outside IDLE.
  assign wr_acc = (state == IDLE) && bus.write;
  assign rd_acc = (state == IDLE) && bus.read && !bus.write;

  assign bus.waitrequest   = (state != IDLE);
  assign bus.readdatavalid = (state == RD_RESP);
  assign irq               = pending;
  assign state_dbg         = state;

  assign be_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                    {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

  // State, latency counter and latched read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= 3'd0;
      rd_addr <= 2'd0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      rd_addr <= rd_addr_next;
    end
  end

  // Next-state decode plus combinational strobes and write data in the accept cycle.
  always_comb begin
    state_next      = state;
    lat_cnt_next    = lat_cnt;
    rd_addr_next    = rd_addr;
    counterIn       = 32'd0;
    counterEnIn     = 1'b0;
    counterDirIn    = 1'b0;
    counterIreIn    = 1'b0;
    counterWe       = 1'b0;
    counterRe       = 1'b0;
    counterConfigWe = 1'b0;
    counterConfigRe = 1'b0;
    counterStatusRe = 1'b0;
    clr_pending     = 1'b0;
    clr_overrun     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          case (bus.address)
            A_COUNTER: begin
              counterWe = 1'b1;
              counterIn = (bus.writedata & be_mask) | (counterOut & ~be_mask);
            end
            A_CONFIG: begin
              counterConfigWe = bus.byteenable[0];
              counterEnIn     = bus.writedata[0];
              counterDirIn    = bus.writedata[1];
              counterIreIn    = bus.writedata[2];
            end
            A_STATUS: begin
              clr_pending = bus.byteenable[0] && bus.writedata[1];
              clr_overrun = bus.byteenable[0] && bus.writedata[2];
            end
            default: ;
          endcase
        end else if (rd_acc) begin
          counterRe       = (bus.address == A_COUNTER);
          counterConfigRe = (bus.address == A_CONFIG);
          counterStatusRe = (bus.address == A_STATUS);
          rd_addr_next    = bus.address;
          lat_cnt_next    = LAT_LOAD;
          state_next      = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_cnt_next = lat_cnt - 3'd1;
        if (lat_cnt <= 3'd1) state_next = RD_RESP;
      end
      RD_RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data source selected by the address the response will carry.
  always_comb begin
    rd_mux = 32'd0;
    case (rd_addr_next)
      A_COUNTER: rd_mux = counterOut;
      A_CONFIG:  rd_mux = {29'd0, counterIreOut, counterDirOut, counterEnOut};
      A_STATUS:  rd_mux = {29'd0, overrun, pending, counterLT1000Out};
      default:   rd_mux = DEVICE_ID;
    endcase
  end

  // Capture read data on the edge that enters RD_RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= 32'd0;
    end else if (state_next == RD_RESP && state != RD_RESP) begin
      bus.readdata <= rd_mux;
    end
  end

  // Sticky interrupt flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (counterIrqOut)    pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
      if (counterIrqOut && pending) overrun <= 1'b1;
      else if (clr_overrun)         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_bus_slave.sv
// Bench for counter_bus_slave: directed register scenarios followed by
// randomized bus/core traffic, all checked against a cycle-level reference
// model built from the register map and read latency rules.
module tb_counter_bus_slave;
  localparam int          LAT    = 2;
  localparam logic [31:0] DEV_ID = 32'hC0DE_0001;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_bus_slave_if bus();

  logic [31:0] counterIn, counterOut;
  logic counterEnIn, counterDirIn, counterIreIn;
  logic counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe;
  logic counterEnOut, counterDirOut, counterIreOut, counterLT1000Out, counterIrqOut;
  logic irq;
  logic [1:0] state_dbg;

  counter_bus_slave #(.READ_LATENCY(LAT), .DEVICE_ID(DEV_ID)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .counterIn(counterIn), .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
    .counterIreIn(counterIreIn), .counterWe(counterWe), .counterRe(counterRe),
    .counterConfigWe(counterConfigWe), .counterConfigRe(counterConfigRe),
    .counterStatusRe(counterStatusRe), .counterOut(counterOut),
    .counterEnOut(counterEnOut), .counterDirOut(counterDirOut),
    .counterIreOut(counterIreOut), .counterLT1000Out(counterLT1000Out),
    .counterIrqOut(counterIrqOut), .irq(irq), .state_dbg(state_dbg)
  );

  // scoreboard and reference model state
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_until = 0;
  bit          rd_open  = 0;
  int          cap_cyc  = 0;
  logic [1:0]  cap_addr = 2'd0;
  logic        m_pend   = 1'b0;
  logic        m_ovr    = 1'b0;
  bit          acc_seen, rdv_seen;
  logic [31:0] last_rdata;
  logic [31:0] d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle_bus();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = 2'd0;
    bus.writedata = 32'd0;
    bus.byteenable = 4'd0;
  endtask

  // One clock cycle: evaluate model and DUT at the falling edge, then
  // advance past the rising edge so the caller can drive the next cycle.
  task automatic cycle();
    bit acc_wr, acc_rd, clr_p, clr_o;
    logic [31:0] exp_in, v;
    logic n_pend, n_ovr;
    @(negedge clk);
    check("irq", 32'(irq), 32'(m_pend));
    check("waitrequest", 32'(bus.waitrequest), 32'(cyc < busy_until));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("readdatavalid", 32'(bus.readdatavalid), 32'd1);
      check("readdata", bus.readdata, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      check("readdatavalid_idle", 32'(bus.readdatavalid), 32'd0);
    end
    if (bus.readdatavalid === 1'b1) begin
      rdv_seen = 1;
      last_rdata = bus.readdata;
    end
    acc_wr = (cyc >= busy_until) && bus.write;
    acc_rd = (cyc >= busy_until) && bus.read && !bus.write;
    if (acc_wr || acc_rd) acc_seen = 1;
    check("counterWe", 32'(counterWe), 32'(acc_wr && bus.address == 2'd0));
    check("counterConfigWe", 32'(counterConfigWe),
          32'(acc_wr && bus.address == 2'd1 && bus.byteenable[0]));
    check("counterRe", 32'(counterRe), 32'(acc_rd && bus.address == 2'd0));
    check("counterConfigRe", 32'(counterConfigRe), 32'(acc_rd && bus.address == 2'd1));
    check("counterStatusRe", 32'(counterStatusRe), 32'(acc_rd && bus.address == 2'd2));
    if (acc_wr && bus.address == 2'd0) begin
      for (int i = 0; i < 4; i++)
        exp_in[8*i +: 8] = bus.byteenable[i] ? bus.writedata[8*i +: 8] : counterOut[8*i +: 8];
      check("counterIn", counterIn, exp_in);
    end else if (!acc_wr) begin
      check("counterIn_zero", counterIn, 32'd0);
    end
    if (acc_wr && bus.address == 2'd1) begin
      check("cfg_bits", {29'd0, counterIreIn, counterDirIn, counterEnIn}, {29'd0, bus.writedata[2:0]});
    end else if (!acc_wr) begin
      check("cfg_bits_zero", {29'd0, counterIreIn, counterDirIn, counterEnIn}, 32'd0);
    end
    if (acc_rd) begin
      rd_open = 1;
      cap_cyc = cyc + LAT - 1;
      cap_addr = bus.address;
      busy_until = cyc + LAT + 1;
    end
    if (rd_open && cap_cyc == cyc) begin
      case (cap_addr)
        2'd0: v = counterOut;
        2'd1: v = {29'd0, counterIreOut, counterDirOut, counterEnOut};
        2'd2: v = {29'd0, m_ovr, m_pend, counterLT1000Out};
        default: v = DEV_ID;
      endcase
      exp_q.push_back(v);
      due_q.push_back(cyc + 1);
      rd_open = 0;
    end
    clr_p = acc_wr && bus.address == 2'd2 && bus.byteenable[0] && bus.writedata[1];
    clr_o = acc_wr && bus.address == 2'd2 && bus.byteenable[0] && bus.writedata[2];
    n_pend = counterIrqOut ? 1'b1 : (clr_p ? 1'b0 : m_pend);
    n_ovr  = (counterIrqOut && m_pend) ? 1'b1 : (clr_o ? 1'b0 : m_ovr);
    m_pend = n_pend;
    m_ovr  = n_ovr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic apply_reset();
    reset = 1'b1;
    idle_bus();
    counterIrqOut = 1'b0;
    #2;
    check("rst_waitrequest", 32'(bus.waitrequest), 32'd0);
    check("rst_readdatavalid", 32'(bus.readdatavalid), 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_strobes", {27'd0, counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pend = 1'b0;
    m_ovr = 1'b0;
    rd_open = 0;
    busy_until = cyc;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus.address = a; bus.writedata = wd; bus.byteenable = be;
    bus.write = 1'b1; bus.read = 1'b0;
    acc_seen = 0;
    for (int k = 0; k < 20 && !acc_seen; k++) cycle();
    if (!acc_seen) check("write_accept_timeout", 32'd0, 32'd1);
    idle_bus();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] data);
    bus.address = a; bus.read = 1'b1; bus.write = 1'b0;
    acc_seen = 0;
    for (int k = 0; k < 20 && !acc_seen; k++) cycle();
    if (!acc_seen) check("read_accept_timeout", 32'd0, 32'd1);
    idle_bus();
    rdv_seen = 0;
    for (int k = 0; k < 20 && !rdv_seen; k++) cycle();
    if (!rdv_seen) check("readdatavalid_timeout", 32'd0, 32'd1);
    data = last_rdata;
    cycle();
  endtask

  initial begin
    idle_bus();
    counterOut = 32'd0; counterEnOut = 0; counterDirOut = 0; counterIreOut = 0;
    counterLT1000Out = 0; counterIrqOut = 0;
    reset = 1'b0;
    #1;
    apply_reset();

    // full-word counter write
    bus.address = 2'd0; bus.writedata = 32'h1234_5678; bus.byteenable = 4'hF; bus.write = 1'b1;
    #1;
    check("wr_full_counterIn", counterIn, 32'h1234_5678);
    check("wr_full_we", 32'(counterWe), 32'd1);
    check("wr_full_wait", 32'(bus.waitrequest), 32'd0);
    cycle();
    idle_bus();

    // byte-merged counter write
    counterOut = 32'hAABB_CCDD;
    bus.address = 2'd0; bus.writedata = 32'h1122_3344; bus.byteenable = 4'b0101; bus.write = 1'b1;
    #1;
    check("wr_merge_counterIn", counterIn, 32'hAA22_CC44);
    cycle();
    idle_bus();

    // ID read
    do_read(2'd3, d);
    check("id_read", d, 32'hC0DE_0001);

    // single interrupt, status read
    counterIrqOut = 1'b1; cycle(); counterIrqOut = 1'b0;
    counterLT1000Out = 1'b1;
    do_read(2'd2, d);
    check("status_after_irq", d, 32'h3);
    check("irq_level", 32'(irq), 32'd1);

    // overrun, then W1C both flags
    counterIrqOut = 1'b1; cycle(); counterIrqOut = 1'b0;
    counterLT1000Out = 1'b0;
    do_read(2'd2, d);
    check("status_overrun", d, 32'h6);
    do_write(2'd2, 32'h6, 4'hF);
    do_read(2'd2, d);
    check("status_cleared", d, 32'h0);
    check("irq_cleared", 32'(irq), 32'd0);

    // set wins over a same-cycle clear
    counterIrqOut = 1'b1; cycle();
    bus.address = 2'd2; bus.writedata = 32'h2; bus.byteenable = 4'h1; bus.write = 1'b1;
    cycle();
    idle_bus(); counterIrqOut = 1'b0;
    check("irq_set_wins", 32'(irq), 32'd1);
    do_read(2'd2, d);
    check("status_set_wins", d, 32'h6);

    // reset during RD_WAIT, then normal reads
    bus.address = 2'd0; bus.read = 1'b1;
    cycle();
    idle_bus();
    apply_reset();
    for (int k = 0; k < 4; k++) cycle();
    counterEnOut = 1'b1; counterDirOut = 1'b0; counterIreOut = 1'b1;
    do_read(2'd1, d);
    check("config_read", d, 32'h5);
    counterOut = 32'h0000_BEEF;
    do_read(2'd0, d);
    check("counter_read", d, 32'h0000_BEEF);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      bus.byteenable = 4'($urandom_range(0, 15));
      bus.write      = ($urandom_range(0, 3) == 0);
      bus.read       = ($urandom_range(0, 2) == 0);
      counterOut     = $urandom;
      counterEnOut   = 1'($urandom_range(0, 1));
      counterDirOut  = 1'($urandom_range(0, 1));
      counterIreOut  = 1'($urandom_range(0, 1));
      counterLT1000Out = 1'($urandom_range(0, 1));
      counterIrqOut  = ($urandom_range(0, 7) == 0);
      if (n == 500) apply_reset();
      cycle();
    end
    idle_bus();
    counterIrqOut = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
